emu_host_axi_arbiter: RTL
=========================

// Module: emu_host_axi_arbiter
// PURPOSE
//  2:1 AXI4 arbiter sharing one host-memory AXI port between two emulator masters:
//  s0 (scan-chain DMA) and s1 (RAM-model backend).
//  Sits between EMU_SYSTEM's host AXI ports and the platform's memory interconnect.
//  Read and write paths are arbitrated independently. Both use round-robin.
//  Responses are routed back by an index bit prepended to the ID.
// PARAMETERS
//  ADDR_W    32  address width, all ports
//  DATA_W    64  data width, all ports (wstrb = DATA_W/8)
//  ID_W      1   upstream ID width; downstream ID width = ID_W+1
//  MAX_OUTS  4   max outstanding read bursts per master (counter width $clog2(MAX_OUTS+1))
// PORTS
//  host_clk     in   1   clock
//  host_rst_n   in   1   asynchronous reset, active-low
//  sN_ar{valid,ready,addr,id,len,size,burst,lock,cache,prot}  in/out  AXI4 AR, N=0,1 (ready out)
//  sN_r{valid,ready,data,resp,id,last}  out/in  AXI4 R to master N (ready in)
//  sN_aw{valid,ready,addr,id,len,size,burst,lock,cache,prot}  in/out  AXI4 AW, master N
//  sN_w{valid,ready,data,strb,last}  in/out  AXI4 W, master N
//  sN_b{valid,ready,resp,id}  out/in  AXI4 B to master N
//  m_ar*/m_r*/m_aw*/m_w*/m_b*  mirrored  downstream AXI4; m_arid/m_awid/m_rid/m_bid are ID_W+1 wide
// BEHAVIOUR
//  Reset (async, host_rst_n=0): all valid/ready outputs 0; rr pointers=s1 (s0 wins first tie);
//   outstanding counters 0; W FSM=W_IDLE. Reset mid-burst drops all state; no recovery.
//  AR path, 0-cycle combinational mux:
//   - Eligible = sN_arvalid && rd_outs[N] < MAX_OUTS.
//   - Grant is registered-held while m_arvalid && !m_arready, so payload stays stable.
//   - Both eligible -> grant != last AR winner. Pointer updates on m_ar handshake.
//   - m_arid = {N, sN_arid}. Only the granted sN_arready = m_arready.
//   - rd_outs[N]++ on AR handshake; -- on m_r handshake with rlast, routed to N.
//     Same cycle -> unchanged.
//  R routing: N = m_rid[ID_W]; sN_rid = m_rid[ID_W-1:0]; m_rready = sN_rready.
//   The other sN_rvalid = 0.
//  W FSM:
//   - W_IDLE: arbitrate AW by round-robin as on AR, held while m_awvalid && !m_awready.
//     On m_aw handshake latch owner and go to W_DATA.
//   - W_DATA: only owner's W passes (m_w* = s<owner>_w*); other swready = 0;
//     all awready/m_awvalid = 0.
//     On m_w handshake with wlast -> W_IDLE. Next AW may be granted the following cycle.
//   - W beats are never accepted before their AW grant. Master W sent early waits (wready=0).
//  B routing: N = m_bid[ID_W], as for R. No write outstanding limit (downstream throttles via AW).
//  ID widths: downstream IDs are exactly 1 bit wider; no ID remap table; no reordering inside block.
//  Invalid m_rid/m_bid values cannot occur (1-bit index covers both masters).
// CONFIGURATION
//  EMU_HOST_ARB_STAT_EN defined:
//   - Adds outputs stat_rd_beats0/1, stat_wr_beats0/1 (32b, wrap at 2^32).
//   - Adds stat_clr (in): sync clear, wins over same-cycle increment.
//   - Counts R/W data handshakes per master.
//  Not defined: ports and counters absent; zero logic.
// STRUCTURE
//  emu_axi_arb_pkg:
//   - typedef enum {W_IDLE,W_DATA} w_state_t
//   - typedef logic mst_idx_t
//   - localparam NUM_MST=2
//  Sub-module emu_rr_arb2:
//   - 2-way round-robin picker with hold input and registered pointer.
//   - One instance each for AR and AW.
// TESTING
//  1 s0 ARVALID, len=3, s1 idle -> m_arid=2'b00; 4 R beats with rid=00 reach s0 only; s1_rvalid stays 0.
//  2 s0 and s1 AR same cycle, back-to-back -> grants s0, s1, s0, s1; m_araddr stable while m_arready=0.
//  3 s1 issues 5 ARs, no R returned, MAX_OUTS=4 -> 5th held with s1_arready=0.
//    Released the cycle after the first rlast; s0 unaffected.
//  4 s0 AW len=7 granted, then s1 AWVALID+WVALID -> s1_awready=s1_wready=0 until s0's 8th wlast.
//    Then s1 AW is granted.
//  5 m_bid=2'b10 and m_rid=2'b01 same cycle -> B to s1 (bid=0), R to s0 (rid=1); m_bready/m_rready follow sN ready.
//  6 host_rst_n low during W_DATA beat 3 -> all valids/readies 0 asynchronously.
//    After release: W_IDLE, counters 0.
//  (STAT_EN) 2 bursts of 4 R beats to s0 -> stat_rd_beats0=8; stat_clr with a beat in the same cycle -> 0.

Source files
------------

// File: rtl/emu_axi_arb_pkg.sv
// Shared types and helpers for the two-master host AXI arbiter.
// Optional statistics counters are enabled by defining EMU_HOST_ARB_STAT_EN.
package emu_axi_arb_pkg;

  localparam int NUM_MST = 2;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } w_state_t;

  typedef logic mst_idx_t;

  // Round-robin choice between two requesters; on a tie the one that did not win last goes.
  function automatic mst_idx_t rr_pick(input logic [1:0] req, input mst_idx_t last);
    mst_idx_t pick;
    pick = ~last;
    if (req == 2'b01)
      pick = 1'b0;
    else if (req == 2'b10)
      pick = 1'b1;
    return pick;
  endfunction

endpackage

// File: rtl/emu_rr_arb2.sv
// Two-way round-robin picker with a registered last-winner pointer and grant hold.
// Part of emu_host_axi_arbiter (EMU_HOST_ARB_STAT_EN does not affect this block).
module emu_rr_arb2
  import emu_axi_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_hold,
  input  logic       i_accept,
  output mst_idx_t   o_gnt,
  output logic       o_valid
);

  mst_idx_t r_last;
  mst_idx_t r_lock_idx;
  logic     r_locked;
  mst_idx_t w_pick;

  assign w_pick  = rr_pick(i_req, r_last);
  // A pending-but-stalled request keeps its grant so the downstream payload cannot switch.
  assign o_gnt   = r_locked ? r_lock_idx : w_pick;
  assign o_valid = i_req[o_gnt];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last     <= 1'b1;
      r_locked   <= 1'b0;
      r_lock_idx <= 1'b0;
    end else begin
      r_locked   <= i_hold;
      r_lock_idx <= o_gnt;
      if (i_accept)
        r_last <= o_gnt;
    end
  end

endmodule

// File: rtl/emu_host_axi_arbiter.sv
// 2:1 AXI4 arbiter: independent round-robin AR and AW/W paths, ID-bit response routing.
// Define EMU_HOST_ARB_STAT_EN to add per-master R/W beat counters with stat_clr.
module emu_host_axi_arbiter
  import emu_axi_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 1,
  parameter int MAX_OUTS = 4
) (
  input  logic                host_clk,
  input  logic                host_rst_n,
`ifdef EMU_HOST_ARB_STAT_EN
  input  logic                stat_clr,
  output logic [31:0]         stat_rd_beats0,
  output logic [31:0]         stat_rd_beats1,
  output logic [31:0]         stat_wr_beats0,
  output logic [31:0]         stat_wr_beats1,
`endif
  // master 0
  input  logic                s0_arvalid,
  output logic                s0_arready,
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic [ID_W-1:0]     s0_arid,
  input  logic [7:0]          s0_arlen,
  input  logic [2:0]          s0_arsize,
  input  logic [1:0]          s0_arburst,
  input  logic                s0_arlock,
  input  logic [3:0]          s0_arcache,
  input  logic [2:0]          s0_arprot,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic [1:0]          s0_rresp,
  output logic [ID_W-1:0]     s0_rid,
  output logic                s0_rlast,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [ID_W-1:0]     s0_awid,
  input  logic [7:0]          s0_awlen,
  input  logic [2:0]          s0_awsize,
  input  logic [1:0]          s0_awburst,
  input  logic                s0_awlock,
  input  logic [3:0]          s0_awcache,
  input  logic [2:0]          s0_awprot,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wlast,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  output logic [1:0]          s0_bresp,
  output logic [ID_W-1:0]     s0_bid,
  // master 1
  input  logic                s1_arvalid,
  output logic                s1_arready,
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic [ID_W-1:0]     s1_arid,
  input  logic [7:0]          s1_arlen,
  input  logic [2:0]          s1_arsize,
  input  logic [1:0]          s1_arburst,
  input  logic                s1_arlock,
  input  logic [3:0]          s1_arcache,
  input  logic [2:0]          s1_arprot,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic [1:0]          s1_rresp,
  output logic [ID_W-1:0]     s1_rid,
  output logic                s1_rlast,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [ID_W-1:0]     s1_awid,
  input  logic [7:0]          s1_awlen,
  input  logic [2:0]          s1_awsize,
  input  logic [1:0]          s1_awburst,
  input  logic                s1_awlock,
  input  logic [3:0]          s1_awcache,
  input  logic [2:0]          s1_awprot,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wlast,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  output logic [1:0]          s1_bresp,
  output logic [ID_W-1:0]     s1_bid,
  // downstream
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [ID_W:0]       m_arid,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arlock,
  output logic [3:0]          m_arcache,
  output logic [2:0]          m_arprot,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic [ID_W:0]       m_rid,
  input  logic                m_rlast,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [ID_W:0]       m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awlock,
  output logic [3:0]          m_awcache,
  output logic [2:0]          m_awprot,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  input  logic [ID_W:0]       m_bid
);

  localparam int CNT_W = $clog2(MAX_OUTS + 1);

  logic [NUM_MST-1:0] w_arvalid_in;
  logic [NUM_MST-1:0] w_ar_elig;
  logic [NUM_MST-1:0] w_aw_req;
  mst_idx_t           w_ar_gnt;
  mst_idx_t           w_aw_gnt;
  logic               w_ar_valid;
  logic               w_aw_valid;
  logic               w_ar_hs;
  logic               w_aw_hs;
  logic               w_r_hs;
  logic               w_w_hs;
  mst_idx_t           w_r_dst;
  mst_idx_t           w_b_dst;
  logic               w_w_idle;
  w_state_t           r_w_state;
  mst_idx_t           r_w_owner;

  // ---------------- AR path ----------------
  assign w_arvalid_in = {s1_arvalid, s0_arvalid};

  genvar gi;
  for (gi = 0; gi < NUM_MST; gi++) begin : g_outs
    logic [CNT_W-1:0] r_cnt;
    logic             w_inc;
    logic             w_dec;
    assign w_inc = w_ar_hs && (w_ar_gnt == 1'(gi));
    assign w_dec = w_r_hs && m_rlast && (w_r_dst == 1'(gi));
    assign w_ar_elig[gi] = w_arvalid_in[gi] && (r_cnt < CNT_W'(MAX_OUTS));
    always_ff @(posedge host_clk or negedge host_rst_n) begin
      if (!host_rst_n)
        r_cnt <= '0;
      else if (w_inc && !w_dec)
        r_cnt <= r_cnt + 1'b1;
      else if (w_dec && !w_inc)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  emu_rr_arb2 u_ar_arb (
    .i_clk    (host_clk),
    .i_rst_n  (host_rst_n),
    .i_req    (w_ar_elig),
    .i_hold   (w_ar_valid & ~m_arready),
    .i_accept (w_ar_hs),
    .o_gnt    (w_ar_gnt),
    .o_valid  (w_ar_valid)
  );

  assign m_arvalid  = host_rst_n & w_ar_valid;
  assign m_araddr   = w_ar_gnt ? s1_araddr  : s0_araddr;
  assign m_arid     = {w_ar_gnt, (w_ar_gnt ? s1_arid : s0_arid)};
  assign m_arlen    = w_ar_gnt ? s1_arlen   : s0_arlen;
  assign m_arsize   = w_ar_gnt ? s1_arsize  : s0_arsize;
  assign m_arburst  = w_ar_gnt ? s1_arburst : s0_arburst;
  assign m_arlock   = w_ar_gnt ? s1_arlock  : s0_arlock;
  assign m_arcache  = w_ar_gnt ? s1_arcache : s0_arcache;
  assign m_arprot   = w_ar_gnt ? s1_arprot  : s0_arprot;
  assign s0_arready = host_rst_n & w_ar_valid & ~w_ar_gnt & m_arready;
  assign s1_arready = host_rst_n & w_ar_valid &  w_ar_gnt & m_arready;
  assign w_ar_hs    = m_arvalid & m_arready;

  // ---------------- R routing ----------------
  assign w_r_dst   = m_rid[ID_W];
  assign s0_rvalid = host_rst_n & m_rvalid & ~w_r_dst;
  assign s1_rvalid = host_rst_n & m_rvalid &  w_r_dst;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rid    = m_rid[ID_W-1:0];
  assign s1_rid    = m_rid[ID_W-1:0];
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign m_rready  = host_rst_n & (w_r_dst ? s1_rready : s0_rready);
  assign w_r_hs    = m_rvalid & m_rready;

  // ---------------- AW / W path ----------------
  assign w_w_idle = (r_w_state == W_IDLE);
  assign w_aw_req = {s1_awvalid, s0_awvalid} & {NUM_MST{w_w_idle}};

  emu_rr_arb2 u_aw_arb (
    .i_clk    (host_clk),
    .i_rst_n  (host_rst_n),
    .i_req    (w_aw_req),
    .i_hold   (w_aw_valid & ~m_awready),
    .i_accept (w_aw_hs),
    .o_gnt    (w_aw_gnt),
    .o_valid  (w_aw_valid)
  );

  assign m_awvalid  = host_rst_n & w_aw_valid;
  assign m_awaddr   = w_aw_gnt ? s1_awaddr  : s0_awaddr;
  assign m_awid     = {w_aw_gnt, (w_aw_gnt ? s1_awid : s0_awid)};
  assign m_awlen    = w_aw_gnt ? s1_awlen   : s0_awlen;
  assign m_awsize   = w_aw_gnt ? s1_awsize  : s0_awsize;
  assign m_awburst  = w_aw_gnt ? s1_awburst : s0_awburst;
  assign m_awlock   = w_aw_gnt ? s1_awlock  : s0_awlock;
  assign m_awcache  = w_aw_gnt ? s1_awcache : s0_awcache;
  assign m_awprot   = w_aw_gnt ? s1_awprot  : s0_awprot;
  assign s0_awready = host_rst_n & w_aw_valid & ~w_aw_gnt & m_awready;
  assign s1_awready = host_rst_n & w_aw_valid &  w_aw_gnt & m_awready;
  assign w_aw_hs    = m_awvalid & m_awready;

  // W beats only flow once their AW has been accepted; the owner holds the bus until wlast.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      r_w_state <= W_IDLE;
      r_w_owner <= 1'b0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_w_owner <= w_aw_gnt;
            r_w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs && m_wlast)
            r_w_state <= W_IDLE;
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  assign m_wvalid  = host_rst_n & ~w_w_idle & (r_w_owner ? s1_wvalid : s0_wvalid);
  assign m_wdata   = r_w_owner ? s1_wdata : s0_wdata;
  assign m_wstrb   = r_w_owner ? s1_wstrb : s0_wstrb;
  assign m_wlast   = r_w_owner ? s1_wlast : s0_wlast;
  assign s0_wready = host_rst_n & ~w_w_idle & ~r_w_owner & m_wready;
  assign s1_wready = host_rst_n & ~w_w_idle &  r_w_owner & m_wready;
  assign w_w_hs    = m_wvalid & m_wready;

  // ---------------- B routing ----------------
  assign w_b_dst   = m_bid[ID_W];
  assign s0_bvalid = host_rst_n & m_bvalid & ~w_b_dst;
  assign s1_bvalid = host_rst_n & m_bvalid &  w_b_dst;
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;
  assign s0_bid    = m_bid[ID_W-1:0];
  assign s1_bid    = m_bid[ID_W-1:0];
  assign m_bready  = host_rst_n & (w_b_dst ? s1_bready : s0_bready);

`ifdef EMU_HOST_ARB_STAT_EN
  logic [31:0] w_stat_rd [NUM_MST];
  logic [31:0] w_stat_wr [NUM_MST];

  for (gi = 0; gi < NUM_MST; gi++) begin : g_stat
    logic [31:0] r_rd;
    logic [31:0] r_wr;
    always_ff @(posedge host_clk or negedge host_rst_n) begin
      if (!host_rst_n) begin
        r_rd <= '0;
        r_wr <= '0;
      end else if (stat_clr) begin
        r_rd <= '0;
        r_wr <= '0;
      end else begin
        if (w_r_hs && (w_r_dst == 1'(gi)))
          r_rd <= r_rd + 32'd1;
        if (w_w_hs && (r_w_owner == 1'(gi)))
          r_wr <= r_wr + 32'd1;
      end
    end
    assign w_stat_rd[gi] = r_rd;
    assign w_stat_wr[gi] = r_wr;
  end

  assign stat_rd_beats0 = w_stat_rd[0];
  assign stat_rd_beats1 = w_stat_rd[1];
  assign stat_wr_beats0 = w_stat_wr[0];
  assign stat_wr_beats1 = w_stat_wr[1];
`endif

endmodule
